// File: rtl/cpu_defs.sv
// Shared CPU constants: boot vector, exception entry,
// sequential fetch step and exception codes.
package cpu_defs;
  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] EXC_ENTRY = 32'hBFC0_0380;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [4:0]  EXC_ADEL  = 5'h04;
endpackage

// File: rtl/fetch_inst_buffer.sv
// Holds the fetched word while the F/D register is
// stalled, so a later SRAM read cannot overwrite it.
module fetch_inst_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        capture,
  input  logic        release_buf,
  input  logic [31:0] rdata,
  output logic        buf_valid,
  output logic [31:0] buf_inst
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid <= 1'b0;
      buf_inst  <= '0;
    end else if (flush || release_buf) begin
      buf_valid <= 1'b0;
    end else if (capture) begin
      buf_valid <= 1'b1;
      buf_inst  <= rdata;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, SRAM issue,
// branch/flush redirect and stall buffering.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [31:0] PC_STEP  = cpu_defs::PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        post_allowin,
  output logic        goon_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_instruction,
  output logic        fs_exc_adel,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_flush,
  input  logic [31:0] exc_target,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata
);

  import cpu_defs::*;

  logic        fs_valid;
  logic        rd_fresh;
  logic        br_pending;
  logic [31:0] br_pend_pc;
  logic [31:0] next_pc;
  logic        fs_allowin;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [31:0] raw_inst;

  assign fs_allowin = !fs_valid || post_allowin;
  assign goon_valid = fs_valid && !exc_flush;

  always_comb begin
    next_pc = fs_pc + PC_STEP;
    priority case (1'b1)
      exc_flush:  next_pc = exc_target;
      br_taken:   next_pc = br_target;
      br_pending: next_pc = br_pend_pc;
      default:    next_pc = fs_pc + PC_STEP;
    endcase
  end

  // reset is sampled directly: the first read issues
  // in the very cycle reset is released
  assign inst_sram_en   = reset && (fs_allowin || exc_flush);
  assign inst_sram_addr = {next_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_valid   <= 1'b0;
      fs_pc      <= RESET_PC - PC_STEP;
      rd_fresh   <= 1'b0;
      br_pending <= 1'b0;
      br_pend_pc <= '0;
    end else begin
      rd_fresh <= inst_sram_en;
      if (inst_sram_en) begin
        fs_valid   <= 1'b1;
        fs_pc      <= next_pc;
        br_pending <= 1'b0;
      end else if (br_taken) begin
        br_pending <= 1'b1;
        br_pend_pc <= br_target;
      end
    end
  end

  fetch_inst_buffer u_buf (
    .clk         (clk),
    .reset       (reset),
    .flush       (exc_flush),
    .capture     (fs_valid && rd_fresh && !post_allowin),
    .release_buf (goon_valid && post_allowin),
    .rdata       (inst_sram_rdata),
    .buf_valid   (buf_valid),
    .buf_inst    (buf_inst)
  );

  assign raw_inst       = buf_valid ? buf_inst : inst_sram_rdata;
  assign fs_exc_adel    = fs_valid && (fs_pc[1:0] != 2'b00);
  assign fs_instruction = (fs_valid && !fs_exc_adel) ? raw_inst : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle
// synchronous SRAM model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        post_allowin;
  logic        goon_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_instruction;
  logic        fs_exc_adel;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_flush;
  logic [31:0] exc_target;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic [31:0] rdata_q = 32'h0;
  logic        garble;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .post_allowin    (post_allowin),
    .goon_valid      (goon_valid),
    .fs_pc           (fs_pc),
    .fs_instruction  (fs_instruction),
    .fs_exc_adel     (fs_exc_adel),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .exc_flush       (exc_flush),
    .exc_target      (exc_target),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk)
    if (inst_sram_en) rdata_q <= word_at(inst_sram_addr);

  assign inst_sram_rdata = garble ? 32'hDEAD_BEEF : rdata_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; post_allowin = 1'b1; br_taken = 1'b0;
    br_target = '0; exc_flush = 1'b0; exc_target = '0;
    garble = 1'b0;
    tick(); tick();
    checks++; if (goon_valid !== 1'b0) begin errors++; $display("FAIL rst_goon got %h exp 0", goon_valid); end
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL rst_en got %h exp 0", inst_sram_en); end
    checks++; if (fs_exc_adel !== 1'b0) begin errors++; $display("FAIL rst_adel got %h exp 0", fs_exc_adel); end
    checks++; if (fs_instruction !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", fs_instruction); end
    reset = 1'b1; #1;
    checks++; if (inst_sram_en !== 1'b1) begin errors++; $display("FAIL c0_en got %h exp 1", inst_sram_en); end
    checks++; if (inst_sram_addr !== 32'hBFC00000) begin errors++; $display("FAIL c0_addr got %h exp BFC00000", inst_sram_addr); end
    tick();
    checks++; if (goon_valid !== 1'b1) begin errors++; $display("FAIL c1_goon got %h exp 1", goon_valid); end
    checks++; if (fs_pc !== 32'hBFC00000) begin errors++; $display("FAIL c1_pc got %h exp BFC00000", fs_pc); end
    checks++; if (fs_instruction !== 32'h0000FFFF) begin errors++; $display("FAIL c1_inst got %h exp 0000FFFF", fs_instruction); end
    tick();
    checks++; if (fs_pc !== 32'hBFC00004) begin errors++; $display("FAIL c2_pc got %h exp BFC00004", fs_pc); end
  endtask

  task automatic test_backpressure();
    tick();
    post_allowin = 1'b0; #1;
    checks++; if (fs_pc !== 32'hBFC00008) begin errors++; $display("FAIL bp_pc got %h exp BFC00008", fs_pc); end
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL bp_en0 got %h exp 0", inst_sram_en); end
    checks++; if (fs_instruction !== 32'h0008FFF7) begin errors++; $display("FAIL bp_inst0 got %h exp 0008FFF7", fs_instruction); end
    tick();
    garble = 1'b1; #1;
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL bp_en1 got %h exp 0", inst_sram_en); end
    checks++; if (fs_instruction !== 32'h0008FFF7) begin errors++; $display("FAIL bp_inst1 got %h exp 0008FFF7", fs_instruction); end
    tick();
    checks++; if (fs_instruction !== 32'h0008FFF7) begin errors++; $display("FAIL bp_inst2 got %h exp 0008FFF7", fs_instruction); end
    checks++; if (goon_valid !== 1'b1) begin errors++; $display("FAIL bp_goon got %h exp 1", goon_valid); end
    tick();
    post_allowin = 1'b1; #1;
    checks++; if (inst_sram_en !== 1'b1) begin errors++; $display("FAIL bp_rel_en got %h exp 1", inst_sram_en); end
    checks++; if (inst_sram_addr !== 32'hBFC0000C) begin errors++; $display("FAIL bp_rel_addr got %h exp BFC0000C", inst_sram_addr); end
    checks++; if (fs_instruction !== 32'h0008FFF7) begin errors++; $display("FAIL bp_rel_inst got %h exp 0008FFF7", fs_instruction); end
    tick();
    garble = 1'b0; #1;
    checks++; if (fs_pc !== 32'hBFC0000C) begin errors++; $display("FAIL bp_next_pc got %h exp BFC0000C", fs_pc); end
    checks++; if (fs_instruction !== 32'h000CFFF3) begin errors++; $display("FAIL bp_next_inst got %h exp 000CFFF3", fs_instruction); end
  endtask

  task automatic test_branch();
    br_taken = 1'b1; br_target = 32'hBFC00100; #1;
    checks++; if (inst_sram_addr !== 32'hBFC00100) begin errors++; $display("FAIL br_addr got %h exp BFC00100", inst_sram_addr); end
    tick();
    br_taken = 1'b0; #1;
    checks++; if (fs_pc !== 32'hBFC00100) begin errors++; $display("FAIL br_pc got %h exp BFC00100", fs_pc); end
    checks++; if (fs_instruction !== 32'h0100FEFF) begin errors++; $display("FAIL br_inst got %h exp 0100FEFF", fs_instruction); end
    post_allowin = 1'b0; br_taken = 1'b1; br_target = 32'hBFC00200; #1;
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL brp_en got %h exp 0", inst_sram_en); end
    tick();
    br_taken = 1'b0; #1;
    checks++; if (fs_pc !== 32'hBFC00100) begin errors++; $display("FAIL brp_hold got %h exp BFC00100", fs_pc); end
    tick();
    post_allowin = 1'b1; #1;
    checks++; if (inst_sram_addr !== 32'hBFC00200) begin errors++; $display("FAIL brp_addr got %h exp BFC00200", inst_sram_addr); end
    tick();
    checks++; if (fs_pc !== 32'hBFC00200) begin errors++; $display("FAIL brp_pc got %h exp BFC00200", fs_pc); end
    checks++; if (fs_instruction !== 32'h0200FDFF) begin errors++; $display("FAIL brp_inst got %h exp 0200FDFF", fs_instruction); end
  endtask

  task automatic test_flush();
    post_allowin = 1'b0;
    tick();
    exc_flush = 1'b1; exc_target = 32'hBFC00380;
    br_taken = 1'b1; br_target = 32'hBFC00500; #1;
    checks++; if (goon_valid !== 1'b0) begin errors++; $display("FAIL fl_goon got %h exp 0", goon_valid); end
    checks++; if (inst_sram_en !== 1'b1) begin errors++; $display("FAIL fl_en got %h exp 1", inst_sram_en); end
    checks++; if (inst_sram_addr !== 32'hBFC00380) begin errors++; $display("FAIL fl_addr got %h exp BFC00380", inst_sram_addr); end
    tick();
    exc_flush = 1'b0; br_taken = 1'b0; #1;
    checks++; if (goon_valid !== 1'b1) begin errors++; $display("FAIL fl_goon1 got %h exp 1", goon_valid); end
    checks++; if (fs_pc !== 32'hBFC00380) begin errors++; $display("FAIL fl_pc got %h exp BFC00380", fs_pc); end
    checks++; if (fs_instruction !== 32'h0380FC7F) begin errors++; $display("FAIL fl_inst got %h exp 0380FC7F", fs_instruction); end
    tick();
    post_allowin = 1'b1; #1;
    checks++; if (inst_sram_addr !== 32'hBFC00384) begin errors++; $display("FAIL fl_drop_br got %h exp BFC00384", inst_sram_addr); end
    tick();
    checks++; if (fs_pc !== 32'hBFC00384) begin errors++; $display("FAIL fl_seq_pc got %h exp BFC00384", fs_pc); end
  endtask

  task automatic test_misaligned();
    br_taken = 1'b1; br_target = 32'hBFC00102; #1;
    checks++; if (inst_sram_addr !== 32'hBFC00100) begin errors++; $display("FAIL mis_addr got %h exp BFC00100", inst_sram_addr); end
    tick();
    br_taken = 1'b0; #1;
    checks++; if (fs_pc !== 32'hBFC00102) begin errors++; $display("FAIL mis_pc got %h exp BFC00102", fs_pc); end
    checks++; if (fs_exc_adel !== 1'b1) begin errors++; $display("FAIL mis_adel got %h exp 1", fs_exc_adel); end
    checks++; if (fs_instruction !== 32'h0) begin errors++; $display("FAIL mis_inst got %h exp 0", fs_instruction); end
    checks++; if (goon_valid !== 1'b1) begin errors++; $display("FAIL mis_goon got %h exp 1", goon_valid); end
    checks++; if (inst_sram_addr !== 32'hBFC00104) begin errors++; $display("FAIL mis_next got %h exp BFC00104", inst_sram_addr); end
  endtask

  task automatic test_wrap();
    br_taken = 1'b1; br_target = 32'hFFFFFFFC;
    tick();
    br_taken = 1'b0; #1;
    checks++; if (fs_exc_adel !== 1'b0) begin errors++; $display("FAIL wr_adel got %h exp 0", fs_exc_adel); end
    checks++; if (inst_sram_addr !== 32'h00000000) begin errors++; $display("FAIL wr_addr got %h exp 00000000", inst_sram_addr); end
    tick();
    checks++; if (fs_pc !== 32'h00000000) begin errors++; $display("FAIL wr_pc got %h exp 00000000", fs_pc); end
    checks++; if (fs_instruction !== 32'h0000FFFF) begin errors++; $display("FAIL wr_inst got %h exp 0000FFFF", fs_instruction); end
  endtask

  task automatic test_reset_mid();
    post_allowin = 1'b0;
    tick();
    reset = 1'b0; #1;
    checks++; if (goon_valid !== 1'b0) begin errors++; $display("FAIL rm_goon got %h exp 0", goon_valid); end
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL rm_en got %h exp 0", inst_sram_en); end
    checks++; if (fs_instruction !== 32'h0) begin errors++; $display("FAIL rm_inst got %h exp 0", fs_instruction); end
    checks++; if (fs_pc !== 32'hBFBFFFFC) begin errors++; $display("FAIL rm_pc got %h exp BFBFFFFC", fs_pc); end
    tick();
    reset = 1'b1; #1;
    checks++; if (inst_sram_addr !== 32'hBFC00000) begin errors++; $display("FAIL rm_addr got %h exp BFC00000", inst_sram_addr); end
    checks++; if (inst_sram_en !== 1'b1) begin errors++; $display("FAIL rm_en1 got %h exp 1", inst_sram_en); end
    tick();
    checks++; if (fs_pc !== 32'hBFC00000) begin errors++; $display("FAIL rm_pc1 got %h exp BFC00000", fs_pc); end
    checks++; if (fs_instruction !== 32'h0000FFFF) begin errors++; $display("FAIL rm_inst1 got %h exp 0000FFFF", fs_instruction); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_branch();
    test_flush();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: generates the PC, issues reads to the 1-cycle-latency synchronous instruction SRAM and presents {pc, instruction} to the F/D pipeline register.
- Uses the same valid/allowin handshake as the pipeline registers: goon_valid drives the F/D register's pre_valid, and post_allowin comes from its cur_allowin.
- Handles branch redirects, exception/ERET flush and misaligned-PC detection.
- Buffers the fetched word while downstream is stalled.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- post_allowin  in  1  F/D register can accept this cycle
- goon_valid  out  1  fetched instruction valid toward F/D register
- fs_pc  out  32  PC of instruction in fetch stage
- fs_instruction  out  32  fetched instruction word
- fs_exc_adel  out  1  fs_pc misaligned (AdEL on fetch)
- br_taken  in  1  one-cycle pulse from decode: redirect the next fetch
- br_target  in  32  branch/jump target, sampled with br_taken
- exc_flush  in  1  one-cycle pulse: exception or ERET, discard pipeline contents
- exc_target  in  32  handler/EPC address, sampled with exc_flush
- inst_sram_en  out  1  SRAM read enable
- inst_sram_addr  out  32  word-aligned SRAM address
- inst_sram_rdata  in  32  SRAM data, valid the cycle after an enabled read

Behaviour:
- State registers: fs_valid, fs_pc, rd_fresh, buf_valid/buf_inst, br_pending/br_pend_pc.
- rd_fresh is inst_sram_en registered; it marks inst_sram_rdata as belonging to fs_pc.
- Reset values (asynchronous on reset low):
  - fs_valid=0, fs_pc=RESET_PC-PC_STEP, rd_fresh=0, buf_valid=0, br_pending=0.
  - Outputs: goon_valid=0, inst_sram_en=0, fs_exc_adel=0, fs_instruction=0.
- fs_allowin = !fs_valid || post_allowin. Fetch is ready-to-go every cycle because data arrives 1 cycle after issue.
- next_pc priority:
  1. exc_flush → exc_target
  2. br_taken → br_target
  3. br_pending → br_pend_pc
  4. otherwise fs_pc+PC_STEP, mod 2^32 (wraps FFFF_FFFC→0000_0000)
- Issue:
  - inst_sram_en = reset_released && (fs_allowin || exc_flush).
  - inst_sram_addr = {next_pc[31:2],2'b00}.
  - On issue: fs_pc<=next_pc, fs_valid<=1, br_pending<=0.
- Latency: address issued in cycle N; fs_instruction valid and goon_valid=1 in cycle N+1.
- Branch:
  - Decode asserts br_taken only while the delay slot occupies fetch (fs_valid=1). The delay slot is never discarded by a branch.
  - If br_taken arrives while fs_allowin=0, set br_pending and latch br_target into br_pend_pc.
  - A later br_taken overwrites the pending target.
- Stall buffer:
  - When fs_valid && rd_fresh && !post_allowin, capture inst_sram_rdata into buf_inst and set buf_valid.
  - fs_instruction = buf_valid ? buf_inst : inst_sram_rdata.
  - buf_valid clears on handoff (goon_valid && post_allowin) or exc_flush.
- Flush:
  - exc_flush forces goon_valid=0 in the same cycle, clears buf_valid and br_pending, and issues exc_target regardless of post_allowin.
  - Next cycle fs_valid=1 with fs_pc=exc_target.
  - exc_flush and br_taken together: exc_flush wins and the branch is dropped.
- Misaligned PC:
  - When fs_pc[1:0]≠0: fs_exc_adel=1 and fs_instruction=32'h0.
  - The SRAM read is still issued at the aligned address, and goon_valid still follows the handshake so the exception travels down the pipe.
- goon_valid = fs_valid && !exc_flush.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight SRAM data is ignored because rd_fresh=0.

Decomposition:
- Shared package (cpu_defs): RESET_PC, EXC_ENTRY default 32'hBFC0_0380, PC_STEP, and the exception-code constant for AdEL.
- One natural sub-module: fetch_inst_buffer, the 32-bit holding register with buf_valid set/clear logic.
- PC/next_pc logic stays in the top.

Test Plan:
- Reset release with post_allowin=1:
  - Cycle 0: en=1, addr=BFC00000.
  - Cycle 1: goon_valid=1, fs_pc=BFC00000, instruction equals the SRAM word.
  - Cycle 2: fs_pc=BFC00004.
- Backpressure: post_allowin=0 for 3 cycles at fs_pc=BFC00008.
  - en=0 throughout; fs_instruction stays at the captured word even if the SRAM changes rdata.
  - On release: handoff, then fs_pc=BFC0000C.
- br_taken with br_target=BFC00100 while post_allowin=1 → next fs_pc=BFC00100.
  - Same pulse with post_allowin=0 → br_pending set; BFC00100 is fetched on the first allowin cycle.
- exc_flush with exc_target=BFC00380 during a stall with buf_valid=1 and simultaneous br_taken:
  - goon_valid=0 that cycle and buffer cleared.
  - Next cycle fs_pc=BFC00380, valid; the branch is discarded.
- br_target=BFC00102:
  - fs_exc_adel=1, fs_instruction=0, inst_sram_addr=BFC00100, goon_valid=1.
- Sequential fetch at fs_pc=FFFFFFFC → next fs_pc=00000000.
- reset pulsed low mid-stall → all outputs return to reset values asynchronously, and the restart fetches RESET_PC.
